// File: rtl/reaction_core.sv
// ---------------------------------------------------------------------------
// reaction_core
//   Multi-player reaction-game engine. A start pulse arms a pseudo-random
//   delay. When the delay expires the engine raises go and counts
//   millisecond ticks until the first player button edge. A press during
//   the delay is a false start. No press before TIME_MAX ticks is a timeout.
//
// Optional feature macro: REACTION_BEST_TIME_EN
//   Defined   : best_ms tracks the lowest valid reaction time since reset.
//   Undefined : best_ms is tied to TIME_MAX.
//
// Ports
//   clk      in   system clock
//   rst      in   asynchronous reset, active low
//   start    in   one-cycle start / re-arm pulse (already debounced)
//   btn      in   debounced button levels, one per player
//   state    out  FSM state code (IDLE=0 ARM=1 GO=2 RESULT=3 FOUL=4)
//   go       out  high only while in GO
//   time_ms  out  reaction time, or the running count while in GO
//   winner   out  index of the responding or offending player
//   foul     out  false-start flag
//   timeout  out  no-press flag
//   best_ms  out  best valid reaction time
// ---------------------------------------------------------------------------
module reaction_core #(
  parameter int CLK_HZ       = 100_000_000,
  parameter int TICK_HZ      = 1000,
  parameter int NUM_PLAYERS  = 2,
  parameter int LFSR_W       = 16,
  parameter int DELAY_RAND_W = 11,
  parameter int MIN_DELAY    = 1000,
  parameter int TIME_MAX     = 9999
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [NUM_PLAYERS-1:0] btn,
  output logic [2:0]             state,
  output logic                   go,
  output logic [13:0]            time_ms,
  output logic [2:0]             winner,
  output logic                   foul,
  output logic                   timeout,
  output logic [13:0]            best_ms
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ARM    = 3'd1,
    ST_GO     = 3'd2,
    ST_RESULT = 3'd3,
    ST_FOUL   = 3'd4
  } state_t;

  localparam int TICK_DIV = CLK_HZ / TICK_HZ;
  localparam int CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
  // Wide enough for MIN_DELAY plus the largest random offset.
  localparam int DELAY_W  = $clog2(MIN_DELAY + 2**DELAY_RAND_W + 1);
  localparam logic [13:0] TIME_MAX_V = 14'(TIME_MAX);

  // Galois feedback masks. The top tap is always set, which keeps the
  // step invertible, so a non-zero state can never fall into all-zero.
  function automatic logic [LFSR_W-1:0] lfsr_taps();
    logic [31:0] t;
    case (LFSR_W)
      8:       t = 32'h0000_00B8;
      16:      t = 32'h0000_B400;
      24:      t = 32'h00E1_0000;
      32:      t = 32'hA300_0000;
      default: t = (32'd1 << (LFSR_W - 1)) | 32'd1;
    endcase
    return t[LFSR_W-1:0];
  endfunction

  localparam logic [LFSR_W-1:0] LFSR_TAPS = lfsr_taps();

  state_t                 state_reg, state_next;
  logic                   go_reg, go_next;
  logic [13:0]            time_reg, time_next;
  logic [2:0]             winner_reg, winner_next;
  logic                   foul_reg, foul_next;
  logic                   timeout_reg, timeout_next;
  logic [DELAY_W-1:0]     delay_reg, delay_next;
  logic [CNT_W-1:0]       cnt_reg;
  logic [LFSR_W-1:0]      lfsr_reg, lfsr_next;
  logic [NUM_PLAYERS-1:0] btn_q;
  logic [NUM_PLAYERS-1:0] btn_edge;
  logic [NUM_PLAYERS-1:0] btn_edge_reg;
  logic [2:0]             first_idx;
  logic                   any_edge;
  logic                   tick;

  // Rising-edge detect per player. The edge itself is registered so that
  // a button rising in cycle N is seen by the FSM in cycle N+1.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_PLAYERS; gi++) begin : g_edge
      assign btn_edge[gi] = btn[gi] & ~btn_q[gi];
    end
  endgenerate

  assign any_edge  = |btn_edge_reg;
  assign tick      = (cnt_reg == CNT_LAST);
  assign lfsr_next = {1'b0, lfsr_reg[LFSR_W-1:1]} ^ (lfsr_reg[0] ? LFSR_TAPS : '0);

  // Lowest-index edging player wins ties.
  always_comb begin
    first_idx = '0;
    for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
      if (btn_edge_reg[i]) first_idx = 3'(i);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= ST_IDLE;
      go_reg       <= 1'b0;
      time_reg     <= '0;
      winner_reg   <= '0;
      foul_reg     <= 1'b0;
      timeout_reg  <= 1'b0;
      delay_reg    <= '0;
      cnt_reg      <= '0;
      lfsr_reg     <= LFSR_W'(1);
      btn_q        <= '0;
      btn_edge_reg <= '0;
    end else begin
      state_reg    <= state_next;
      go_reg       <= go_next;
      time_reg     <= time_next;
      winner_reg   <= winner_next;
      foul_reg     <= foul_next;
      timeout_reg  <= timeout_next;
      delay_reg    <= delay_next;
      lfsr_reg     <= lfsr_next;
      btn_q        <= btn;
      btn_edge_reg <= btn_edge;
      // Restart the tick phase on every state entry so the first tick of
      // a state lands exactly TICK_DIV cycles after entering it.
      if (state_next != state_reg || tick) cnt_reg <= '0;
      else                                 cnt_reg <= cnt_reg + 1'b1;
    end
  end

  always_comb begin
    state_next   = state_reg;
    go_next      = go_reg;
    time_next    = time_reg;
    winner_next  = winner_reg;
    foul_next    = foul_reg;
    timeout_next = timeout_reg;
    delay_next   = delay_reg;

    case (state_reg)
      ST_IDLE, ST_RESULT, ST_FOUL: begin
        if (start) begin
          state_next   = ST_ARM;
          go_next      = 1'b0;
          time_next    = '0;
          winner_next  = '0;
          foul_next    = 1'b0;
          timeout_next = 1'b0;
          delay_next   = DELAY_W'(MIN_DELAY) + DELAY_W'(lfsr_reg[DELAY_RAND_W-1:0]);
        end
      end

      ST_ARM: begin
        if (any_edge) begin
          state_next  = ST_FOUL;
          foul_next   = 1'b1;
          winner_next = first_idx;
        end else if (tick) begin
          // The final tick moves straight to GO so go rises the next cycle.
          if (delay_reg <= DELAY_W'(1)) begin
            state_next = ST_GO;
            go_next    = 1'b1;
            time_next  = '0;
            delay_next = '0;
          end else begin
            delay_next = delay_reg - 1'b1;
          end
        end
      end

      ST_GO: begin
        // A press beats a coincident tick: the time is frozen unincremented.
        if (any_edge) begin
          state_next  = ST_RESULT;
          go_next     = 1'b0;
          winner_next = first_idx;
        end else if (tick) begin
          if (time_reg >= TIME_MAX_V - 14'd1) begin
            state_next   = ST_RESULT;
            go_next      = 1'b0;
            time_next    = TIME_MAX_V;
            timeout_next = 1'b1;
            winner_next  = '0;
          end else begin
            time_next = time_reg + 14'd1;
          end
        end
      end

      default: begin
        state_next = ST_IDLE;
        go_next    = 1'b0;
      end
    endcase
  end

`ifdef REACTION_BEST_TIME_EN
  logic [13:0] best_reg, best_next;

  // Only a real press in GO can improve the record; fouls and timeouts
  // leave it untouched.
  always_comb begin
    best_next = best_reg;
    if (state_reg == ST_GO && any_edge && time_reg < best_reg) best_next = time_reg;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) best_reg <= TIME_MAX_V;
    else      best_reg <= best_next;
  end

  assign best_ms = best_reg;
`else
  assign best_ms = TIME_MAX_V;
`endif

  assign state   = state_reg;
  assign go      = go_reg;
  assign time_ms = time_reg;
  assign winner  = winner_reg;
  assign foul    = foul_reg;
  assign timeout = timeout_reg;

endmodule

// File: doc/reaction_core.md
# reaction_core

Parametrised multi-player reaction-game engine for the FPGA reaction game top level. On `start` it arms a pseudo-random foreground delay, raises `go`, then timestamps the first player button edge in millisecond ticks. It also detects false starts and timeouts, and optionally tracks the best time. The block's outputs feed the display and LED logic directly; the 7-segment driver still owns digit multiplexing.

## Interface
Parameters:
- `CLK_HZ`, 100_000_000, input clock frequency.
- `TICK_HZ`, 1000, timing tick rate (1 ms).
- `NUM_PLAYERS`, 2, button channels (1..8).
- `LFSR_W`, 16, internal LFSR width.
- `DELAY_RAND_W`, 11, LFSR bits added to the base delay (0..2047 ticks).
- `MIN_DELAY`, 1000, base arm delay in ticks.
- `TIME_MAX`, 9999, saturation/timeout value in ticks.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse, already debounced.
- `btn`  in  NUM_PLAYERS  debounced button levels.
- `state`  out  3  FSM state code.
- `go`  out  1  high only in GO.
- `time_ms`  out  14  reaction time or running count.
- `winner`  out  3  index of the responding or offending player.
- `foul`  out  1  false-start flag.
- `timeout`  out  1  no-press flag.
- `best_ms`  out  14  best valid time (see Configuration).

## Operation
- FSM states and codes:
  - IDLE=0
  - ARM=1
  - GO=2
  - RESULT=3
  - FOUL=4
- Internal Galois LFSR:
  - Seed 1 at reset.
  - Steps every `clk`.
  - Never all-zero.
- Button edges: `btn` is registered once into `btn_q`; `edge = btn & ~btn_q`. Only rising edges count, so a held button never triggers.
- Tick counter:
  - Counts 0..CLK_HZ/TICK_HZ-1 and emits a one-cycle tick at terminal count.
  - Clears on every state entry.
- IDLE → ARM on `start`:
  - Load `delay = MIN_DELAY + lfsr[DELAY_RAND_W-1:0]`.
  - Clear `time_ms`, `winner`, `foul`, `timeout`.
- ARM:
  - Decrement `delay` per tick. At 0 → GO with `time_ms` = 0.
  - Any edge → FOUL. `winner` = lowest-index edging player; `foul` = 1.
- GO:
  - `time_ms` += 1 per tick.
  - Edge → RESULT, with `winner` = lowest-index edging player and `time_ms` frozen.
  - `time_ms` reaching TIME_MAX → RESULT, with `timeout` = 1 and `winner` = 0.
- RESULT / FOUL:
  - Hold all outputs.
  - `start` → ARM (re-arm, same actions as from IDLE).
- `start` in ARM or GO is ignored.
- Simultaneous edges in one cycle: the lowest index wins.
- Simultaneous edge and tick in the GO cycle: the edge wins. `time_ms` is not incremented.
- `time_ms` never exceeds TIME_MAX.

## Timing
- All outputs are registered.
- Reset values:
  - `state`=IDLE, `go`=0, `time_ms`=0, `winner`=0, `foul`=0, `timeout`=0, `best_ms`=TIME_MAX.
  - `btn_q`=0, tick counter 0, LFSR seed 1.
- Button latency: `btn` rising in cycle N → edge in N+1 → `state`/`time_ms` frozen in N+2.
- `start` in cycle N → `state`=ARM in cycle N+1.
- First tick occurs CLK_HZ/TICK_HZ cycles after state entry.
- ARM duration is exactly `delay` ticks. `go` rises the cycle after the final tick.
- Asserting `rst` mid-operation returns all state to reset values immediately. `best_ms` is cleared as well.

## Configuration
- `REACTION_BEST_TIME_EN` defined:
  - On GO → RESULT with `timeout`=0 and `time_ms` < `best_ms`, `best_ms` takes the new `time_ms` in the same cycle `state` becomes RESULT.
  - Fouls and timeouts never update it.
- Undefined: no best register; `best_ms` is tied to TIME_MAX.

## Test plan
All scenarios use `CLK_HZ`=10, `TICK_HZ`=1, `MIN_DELAY`=3, `DELAY_RAND_W`=2.
- Normal round:
  - Stimulus: `start`, wait for `go`, raise `btn[1]` 47 cycles later.
  - Required: `state`=RESULT, `winner`=1, `time_ms`=4, `foul`=0.
- False start:
  - Stimulus: `start`, raise `btn[0]` 5 cycles later.
  - Required: `state`=FOUL, `foul`=1, `winner`=0, `go` never asserted.
- Held button and tie:
  - Stimulus: hold `btn[0]` through ARM.
  - Required: no foul.
  - Stimulus: in GO, raise `btn[1:0]` edges in the same cycle after the hold is released.
  - Required: `winner`=0.
- Timeout:
  - Stimulus: `TIME_MAX`=20, no press.
  - Required: after 200 cycles in GO, `state`=RESULT, `timeout`=1, `time_ms`=20.
- Best time with `REACTION_BEST_TIME_EN`:
  - Stimulus: rounds of 8, 5, then 9 ticks.
  - Required: `best_ms` = 8, then 5, then 5.
  - Stimulus: a foul round.
  - Required: `best_ms` unchanged.
- Reset mid-GO:
  - Stimulus: drive `rst`=0 for one cycle.
  - Required: all outputs at reset values. A following `start` runs a full round.
